// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retire reorder buffer returning superseded physical regs to the free list
// Optional exception flush: define ROB_EXCEPTION_EN.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 5,
    parameter int AREG_W = 5,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic              dispatch_has_dest,
    input  logic [AREG_W-1:0] dispatch_arch_dest,
    input  logic [PREG_W-1:0] dispatch_phys_dest,
    input  logic [PREG_W-1:0] dispatch_dest_old,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic              commit_valid,
    output logic              commit_flag,
    output logic [PREG_W-1:0] commit_phys_reg,
    output logic [AREG_W-1:0] commit_arch_dest,
    output logic [PREG_W-1:0] commit_phys_dest,
`ifdef ROB_EXCEPTION_EN
    input  logic              complete_exc,
    output logic              flush,
`endif
    output logic              empty
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
    logic [DEPTH-1:0]  has_dest_q;
    logic [AREG_W-1:0] arch_q [DEPTH];
    logic [PREG_W-1:0] phys_q [DEPTH];
    logic [PREG_W-1:0] old_q  [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic head_ready, flush_now, commit_fire, dispatch_fire, complete_hit;

    assign head_ready    = valid_q[head_q] & done_q[head_q];
    assign complete_hit  = complete_valid & valid_q[complete_tag];

`ifdef ROB_EXCEPTION_EN
    logic [DEPTH-1:0] exc_q, exc_d;
    assign flush_now = head_ready & exc_q[head_q];
    assign flush     = flush_now;

    always_comb begin
        exc_d = exc_q;
        if (complete_hit)  exc_d[complete_tag] = complete_exc;
        if (dispatch_fire) exc_d[tail_q]       = 1'b0;
        if (flush_now)     exc_d               = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) exc_q <= '0;
        else       exc_q <= exc_d;
    end
`else
    assign flush_now = 1'b0;
`endif

    // A faulting head blocks retirement and refuses new work in the flush cycle.
    assign commit_fire    = head_ready & ~flush_now;
    assign dispatch_ready = (count_q != FULL_CNT) & ~flush_now;
    assign dispatch_fire  = dispatch_valid & dispatch_ready;

    assign dispatch_tag     = tail_q;
    assign empty            = (count_q == '0);
    assign commit_valid     = commit_fire;
    assign commit_flag      = commit_fire & has_dest_q[head_q];
    assign commit_phys_reg  = old_q[head_q];
    assign commit_arch_dest = arch_q[head_q];
    assign commit_phys_dest = phys_q[head_q];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (complete_hit) done_d[complete_tag] = 1'b1;
        if (commit_fire)  valid_d[head_q]      = 1'b0;
        if (dispatch_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        if (flush_now) begin
            valid_d = '0;
            done_d  = '0;
        end
    end

    always_comb begin
        head_d  = commit_fire   ? head_q + TAG_W'(1) : head_q;
        tail_d  = dispatch_fire ? tail_q + TAG_W'(1) : tail_q;
        count_d = count_q;
        if (dispatch_fire && !commit_fire)      count_d = count_q + (TAG_W+1)'(1);
        else if (!dispatch_fire && commit_fire) count_d = count_q - (TAG_W+1)'(1);
        if (flush_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (dispatch_fire) begin
            has_dest_q[tail_q] <= dispatch_has_dest;
            arch_q[tail_q]     <= dispatch_arch_dest;
            phys_q[tail_q]     <= dispatch_phys_dest;
            old_q[tail_q]      <= dispatch_dest_old;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer (optional ROB_EXCEPTION_EN)
module tb_reorder_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dispatch_valid = 1'b0, dispatch_ready, dispatch_has_dest = 1'b0;
    logic [4:0] dispatch_arch_dest = '0, dispatch_phys_dest = '0, dispatch_dest_old = '0;
    logic [2:0] dispatch_tag;
    logic       complete_valid = 1'b0;
    logic [2:0] complete_tag = '0;
    logic       complete_exc = 1'b0;
    logic       commit_valid, commit_flag, empty;
    logic [4:0] commit_phys_reg, commit_arch_dest, commit_phys_dest;
`ifdef ROB_EXCEPTION_EN
    logic       flush;
`endif

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_has_dest(dispatch_has_dest), .dispatch_arch_dest(dispatch_arch_dest),
        .dispatch_phys_dest(dispatch_phys_dest), .dispatch_dest_old(dispatch_dest_old),
        .dispatch_tag(dispatch_tag),
        .complete_valid(complete_valid), .complete_tag(complete_tag),
        .commit_valid(commit_valid), .commit_flag(commit_flag),
        .commit_phys_reg(commit_phys_reg), .commit_arch_dest(commit_arch_dest),
        .commit_phys_dest(commit_phys_dest),
`ifdef ROB_EXCEPTION_EN
        .complete_exc(complete_exc), .flush(flush),
`endif
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {int tag; bit hd; int arch; int phys; int old; bit done; bit exc;} ent_t;
    typedef struct {bit flag; int arch; int phys; int old;} cmt_t;

    ent_t mq[$];
    cmt_t exp_q[$];
    int   tail_m = 0;
    int   tests = 0, fails = 0;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_head_done();
        return mq.size() > 0 && mq[0].done;
    endfunction

    function automatic bit m_flush();
        return m_head_done() && mq[0].exc;
    endfunction

    // Commit monitor: every retirement must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        if (!reset && commit_valid) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 1, 0);
            end else begin
                cmt_t e;
                e = exp_q.pop_front();
                chk("commit_flag", int'(commit_flag), int'(e.flag));
                chk("commit_arch_dest", int'(commit_arch_dest), e.arch);
                chk("commit_phys_dest", int'(commit_phys_dest), e.phys);
                chk("commit_phys_reg", int'(commit_phys_reg), e.old);
            end
        end
    end

    task automatic check_outputs();
        bit fl;
        fl = m_flush();
        chk("dispatch_ready", int'(dispatch_ready), int'(mq.size() < DEPTH && !fl));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("dispatch_tag", int'(dispatch_tag), tail_m);
        chk("commit_valid", int'(commit_valid), int'(m_head_done() && !fl));
`ifdef ROB_EXCEPTION_EN
        chk("flush", int'(flush), int'(fl));
`endif
    endtask

    task automatic model_edge();
        bit full;
        full = (mq.size() == DEPTH);
        if (m_flush()) begin
            mq.delete();
            exp_q.delete();
            tail_m = 0;
            return;
        end
        if (m_head_done()) void'(mq.pop_front());
        if (complete_valid)
            foreach (mq[i])
                if (mq[i].tag == int'(complete_tag)) begin
                    mq[i].done = 1'b1;
                    mq[i].exc  = complete_exc;
                end
        if (dispatch_valid && !full) begin
            ent_t e;
            cmt_t c;
            e.tag = tail_m; e.hd = dispatch_has_dest; e.arch = int'(dispatch_arch_dest);
            e.phys = int'(dispatch_phys_dest); e.old = int'(dispatch_dest_old);
            e.done = 1'b0; e.exc = 1'b0;
            mq.push_back(e);
            c.flag = dispatch_has_dest; c.arch = e.arch; c.phys = e.phys; c.old = e.old;
            exp_q.push_back(c);
            tail_m = (tail_m + 1) % DEPTH;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic drive(input bit dv, input bit hd, input int arch, input int phys, input int old,
                         input bit cv, input int ctag, input bit cx);
        dispatch_valid     = dv;
        dispatch_has_dest  = hd;
        dispatch_arch_dest = 5'(arch);
        dispatch_phys_dest = 5'(phys);
        dispatch_dest_old  = 5'(old);
        complete_valid     = cv;
        complete_tag       = 3'(ctag);
        complete_exc       = cx;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic check_reset_values(input string tagname);
        chk({tagname, "_ready"}, int'(dispatch_ready), 1);
        chk({tagname, "_empty"}, int'(empty), 1);
        chk({tagname, "_tag"}, int'(dispatch_tag), 0);
        chk({tagname, "_commit_valid"}, int'(commit_valid), 0);
        chk({tagname, "_commit_flag"}, int'(commit_flag), 0);
`ifdef ROB_EXCEPTION_EN
        chk({tagname, "_flush"}, int'(flush), 0);
`endif
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_reset_values("reset");
        mq.delete();
        exp_q.delete();
        tail_m = 0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        // Single dispatch, complete, commit.
        drive(1, 1, 3, 12, 3, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0);  tick();
        idle(1);
        chk("single_committed_empty", int'(empty), 1);
        idle(1);

        // Out-of-order completion retires in order.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, i + 1, 20 + i, 10 + i, 0, 0, 0);
            tick();
        end
        for (int i = 2; i >= 0; i--) begin
            drive(0, 0, 0, 0, 0, 1, (1 + i) % DEPTH, 0);
            tick();
        end
        idle(4);

        // Fill, stall the 9th, then wrap.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, i, i + 8, i + 16, 0, 0, 0);
            tick();
        end
        drive(1, 1, 30, 31, 29, 0, 0, 0);
        #1 chk("full_ready", int'(dispatch_ready), 0);
        tick();
        drive(1, 1, 30, 31, 29, 1, 0, 0);
        tick();
        drive(1, 1, 30, 31, 29, 0, 0, 0);
        #1 chk("full_commit_still_stalled", int'(dispatch_ready), 0);
        tick();
        #1 chk("wrap_ready", int'(dispatch_ready), 1);
        chk("wrap_tag", int'(dispatch_tag), 0);
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 1, i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        idle(3);

        // No-dest instruction and a completion to an invalid tag.
        apply_reset();
        drive(1, 0, 4, 9, 7, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 5, 0); tick();
        idle(2);
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        idle(2);

        // Reset with entries in flight, some done but not at head.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i, i, i, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 2, 0); tick();
        #3;
        apply_reset();
        idle(4);

`ifdef ROB_EXCEPTION_EN
        drive(1, 1, 1, 2, 3, 0, 0, 0); tick();
        drive(1, 1, 4, 5, 6, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 1); tick();
        drive(1, 1, 7, 8, 9, 0, 0, 0);
        #1 chk("exc_flush", int'(flush), 1);
        chk("exc_commit_flag", int'(commit_flag), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("exc_after_empty", int'(empty), 1);
        chk("exc_after_tag", int'(dispatch_tag), 0);
        chk("exc_after_flush", int'(flush), 0);
        idle(2);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit cv, cx;
            int ct;
            cv = 1'b0; ct = 0; cx = 1'b0;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                cv = 1'b1;
                ct = mq[$urandom_range(0, mq.size() - 1)].tag;
            end else if ($urandom_range(0, 3) == 0) begin
                cv = 1'b1;
                ct = $urandom_range(0, DEPTH - 1);
            end
`ifdef ROB_EXCEPTION_EN
            cx = ($urandom_range(0, 15) == 0);
`endif
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), cv, ct, cx);
            tick();
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, mq.size() > 0, mq.size() > 0 ? mq[0].tag : 0, 0);
            tick();
        end
        idle(2);
        chk("drain_empty", int'(empty), 1);
        chk("drain_scoreboard", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
